// File: rtl/enigma_pkg.sv
// enigma_pkg
//   Shared types and constants for the Enigma core scheduler slice.
//   - sched_state_t : scheduler FSM states
//   - ASCII_A/ASCII_Z : letter range that is routed through the cipher core
//   - TIMEOUT_CHAR : byte substituted for a result the core never produced
//   - CH_ENC/CH_DEC : channel ids; the channel id doubles as the core's decrypt flag
package enigma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SET,
    GRANT,
    ISSUE,
    WAIT,
    NEXT
  } sched_state_t;

  localparam logic [7:0] ASCII_A      = 8'h41;
  localparam logic [7:0] ASCII_Z      = 8'h5A;
  localparam logic [7:0] TIMEOUT_CHAR = 8'h3F;
  localparam logic       CH_ENC       = 1'b0;
  localparam logic       CH_DEC       = 1'b1;

  function automatic logic is_letter(input logic [7:0] b);
    return (b >= ASCII_A) && (b <= ASCII_Z);
  endfunction

endpackage

// File: rtl/enigma_rr_arb.sv
// enigma_rr_arb
//   Two-way round-robin arbiter, granted per message.
//   Ports:
//     clk, reset_n   clock, synchronous active-low reset
//     req[1:0]       per-channel requests
//     take           holder is latched this cycle (message starts)
//     msg_end        holder's message finished (1-cycle pulse)
//     grant[1:0]     one-hot combinational grant
//     gnt_id         index of the granted channel
//   The pointer only moves at message end, and only when the other channel was
//   already waiting when the holder was picked; with no contention the last
//   winner keeps priority.
module enigma_rr_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       take,
  input  logic       msg_end,
  output logic [1:0] grant,
  output logic       gnt_id
);

  logic ptr;
  logic holder;
  logic contend;

  always_comb begin
    gnt_id = ptr;
    if (!req[ptr]) gnt_id = ~ptr;
    grant = 2'b00;
    if (|req) grant[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr     <= 1'b0;
      holder  <= 1'b0;
      contend <= 1'b0;
    end else begin
      if (take) begin
        holder  <= gnt_id;
        contend <= req[~gnt_id];
      end
      if (msg_end && contend) ptr <= ~holder;
    end
  end

endmodule

// File: rtl/enigma_core_sched.sv
// enigma_core_sched
//   Shares one Enigma cipher core between an encrypting requester (ch0) and a
//   decrypting requester (ch1), one whole message at a time. Letters go through
//   the core; any other byte bypasses it. A core that never answers is recovered
//   by a timeout that substitutes TIMEOUT_CHAR and forces a core re-set.
//   Parameters: TIMEOUT_CYC (cycles from ISSUE to forced abort, >=2),
//               TO_W (timeout counter width, must hold TIMEOUT_CYC)
//   Ports:
//     clk, reset_n                          clock, synchronous active-low reset
//     cfg_load                              key/rotor change pulse
//     chN_valid/chN_data/chN_last/chN_ready byte streams, N = 0,1
//     out_valid/out_ready/out_data/out_ch/out_last/out_err  1-entry result register
//     core_set/core_en/core_valid/core_din/core_dec/core_dout/core_done  core pins
//   Optional: define ENIGMA_SCHED_STATS_EN to add stat_chars0/stat_chars1
//   (delivered results per channel) and stat_timeouts, all saturating.
module enigma_core_sched
  import enigma_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_load,
  input  logic        ch0_valid,
  input  logic [7:0]  ch0_data,
  input  logic        ch0_last,
  output logic        ch0_ready,
  input  logic        ch1_valid,
  input  logic [7:0]  ch1_data,
  input  logic        ch1_last,
  output logic        ch1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_ch,
  output logic        out_last,
  output logic        out_err,
  output logic        core_set,
  output logic        core_en,
  output logic        core_valid,
  output logic [7:0]  core_din,
  output logic        core_dec,
  input  logic [7:0]  core_dout,
  input  logic        core_done
`ifdef ENIGMA_SCHED_STATS_EN
  ,
  output logic [15:0] stat_chars0,
  output logic [15:0] stat_chars1,
  output logic [7:0]  stat_timeouts
`endif
);

  sched_state_t    state, state_nx;
  logic            set_pend;
  logic            byte_last;
  logic [TO_W-1:0] timer;
  logic [1:0]      arb_grant;
  logic            arb_id;
  logic            take, msg_end;
  logic            cur_valid, cur_last, accept_ok, accept, letter;
  logic [7:0]      cur_data;
  logic            timeout_hit, out_take;

  enigma_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({ch1_valid, ch0_valid}),
    .take    (take),
    .msg_end (msg_end),
    .grant   (arb_grant),
    .gnt_id  (arb_id)
  );

  // core_dec is the granted channel register, so it cannot change mid-message.
  always_comb begin
    cur_valid   = (core_dec == CH_DEC) ? ch1_valid : ch0_valid;
    cur_data    = (core_dec == CH_DEC) ? ch1_data  : ch0_data;
    cur_last    = (core_dec == CH_DEC) ? ch1_last  : ch0_last;
    accept_ok   = ((state == GRANT) || (state == NEXT)) && !out_valid;
    ch0_ready   = accept_ok && (core_dec == CH_ENC);
    ch1_ready   = accept_ok && (core_dec == CH_DEC);
    accept      = accept_ok && cur_valid;
    letter      = is_letter(cur_data);
    timeout_hit = (state == WAIT) && !core_done && (timer == TO_W'(TIMEOUT_CYC - 1));
    out_take    = out_valid && out_ready;
    core_set    = (state == SET);
    core_valid  = (state == ISSUE);
    core_en     = (state == ISSUE) || ((state == WAIT) && !timeout_hit);
  end

  // A pending set (or a cfg_load arriving this very cycle) beats a new grant,
  // so the core is always re-keyed between messages, never inside one.
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    msg_end  = 1'b0;
    case (state)
      IDLE: begin
        if (set_pend || cfg_load) begin
          state_nx = SET;
        end else if (|arb_grant) begin
          state_nx = GRANT;
          take     = 1'b1;
        end
      end
      SET:   state_nx = IDLE;
      GRANT,
      NEXT: begin
        if (accept) begin
          state_nx = letter ? ISSUE : NEXT;
        end else if ((state == NEXT) && out_take && out_last) begin
          state_nx = IDLE;
          msg_end  = 1'b1;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT:  if (core_done || timeout_hit) state_nx = NEXT;
      default: state_nx = IDLE;
    endcase
  end

  // Loads into the out register never collide with a held result: bytes are
  // only accepted while it is empty, and WAIT is only reached from an accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      set_pend  <= 1'b1;
      core_dec  <= CH_ENC;
      core_din  <= 8'h00;
      byte_last <= 1'b0;
      timer     <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_ch    <= 1'b0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (cfg_load || timeout_hit) set_pend <= 1'b1;
      else if (state == SET)        set_pend <= 1'b0;
      if (take) core_dec <= arb_id;
      if (accept) begin
        byte_last <= cur_last;
        if (letter) core_din <= cur_data;
      end
      if (accept && letter)                        timer <= '0;
      else if ((state == ISSUE) || (state == WAIT)) timer <= timer + 1'b1;
      if (out_take) out_valid <= 1'b0;
      if (accept && !letter) begin
        out_valid <= 1'b1;
        out_data  <= cur_data;
        out_ch    <= core_dec;
        out_last  <= cur_last;
        out_err   <= 1'b0;
      end else if ((state == WAIT) && core_done) begin
        out_valid <= 1'b1;
        out_data  <= core_dout;
        out_ch    <= core_dec;
        out_last  <= byte_last;
        out_err   <= 1'b0;
      end else if (timeout_hit) begin
        out_valid <= 1'b1;
        out_data  <= TIMEOUT_CHAR;
        out_ch    <= core_dec;
        out_last  <= byte_last;
        out_err   <= 1'b1;
      end
    end
  end

`ifdef ENIGMA_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_chars0   <= 16'h0000;
      stat_chars1   <= 16'h0000;
      stat_timeouts <= 8'h00;
    end else begin
      if (out_take && !out_ch && (stat_chars0 != 16'hFFFF)) stat_chars0 <= stat_chars0 + 16'd1;
      if (out_take &&  out_ch && (stat_chars1 != 16'hFFFF)) stat_chars1 <= stat_chars1 + 16'd1;
      if (timeout_hit && (stat_timeouts != 8'hFF)) stat_timeouts <= stat_timeouts + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_enigma_core_sched.sv
// tb_enigma_core_sched
//   Directed bench for enigma_core_sched with a core stub that answers 8 cycles
//   after core_valid with din+1 (or never, while stub_hang is set).
//   TIMEOUT_CYC is 16 here so the hung-core abort is quick to reach.
module tb_enigma_core_sched;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_load = 1'b0;
  logic       ch0_valid = 1'b0, ch1_valid = 1'b0;
  logic [7:0] ch0_data = 8'h00, ch1_data = 8'h00;
  logic       ch0_last = 1'b0, ch1_last = 1'b0;
  logic       ch0_ready, ch1_ready;
  logic       out_valid, out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_ch, out_last, out_err;
  logic       core_set, core_en, core_valid, core_dec, core_done;
  logic [7:0] core_din, core_dout;
`ifdef ENIGMA_SCHED_STATS_EN
  logic [15:0] stat_chars0, stat_chars1;
  logic [7:0]  stat_timeouts;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int set_cnt = 0;
  int valid_cnt = 0;

  logic [3:0] stub_cnt = 4'd0;
  logic [7:0] stub_din = 8'h00;
  logic       stub_hang = 1'b0;

  enigma_core_sched #(.TIMEOUT_CYC(16), .TO_W(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_load   (cfg_load),
    .ch0_valid  (ch0_valid),
    .ch0_data   (ch0_data),
    .ch0_last   (ch0_last),
    .ch0_ready  (ch0_ready),
    .ch1_valid  (ch1_valid),
    .ch1_data   (ch1_data),
    .ch1_last   (ch1_last),
    .ch1_ready  (ch1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_last   (out_last),
    .out_err    (out_err),
    .core_set   (core_set),
    .core_en    (core_en),
    .core_valid (core_valid),
    .core_din   (core_din),
    .core_dec   (core_dec),
    .core_dout  (core_dout),
    .core_done  (core_done)
`ifdef ENIGMA_SCHED_STATS_EN
    ,
    .stat_chars0   (stat_chars0),
    .stat_chars1   (stat_chars1),
    .stat_timeouts (stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  // Core stub and event monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_set)   set_cnt   <= set_cnt + 1;
    if (core_valid) valid_cnt <= valid_cnt + 1;
    if (core_valid) begin
      stub_cnt <= 4'd8;
      stub_din <= core_din;
    end else if (stub_cnt != 4'd0) begin
      stub_cnt <= stub_cnt - 4'd1;
    end
  end

  assign core_done = (stub_cnt == 4'd1) && !stub_hang;
  assign core_dout = stub_din + 8'd1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] allOutputs();
    return {6'd0, out_valid, out_data, out_ch, out_last, out_err, core_set, core_en,
            core_valid, core_din, core_dec, ch0_ready, ch1_ready};
  endfunction

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    ch0_valid = 1'b0; ch1_valid = 1'b0; cfg_load = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", allOutputs(), 32'd0);
    reset_n = 1'b1;
  endtask

  // Offer one byte and return on the negedge after it is accepted.
  task automatic applyStimulus(input bit ch, input logic [7:0] d, input bit last);
    int n = 0;
    if (ch) begin ch1_valid = 1'b1; ch1_data = d; ch1_last = last; end
    else    begin ch0_valid = 1'b1; ch0_data = d; ch0_last = last; end
    while (!(ch ? ch1_ready : ch0_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept", ch ? ch1_ready : ch0_ready, 1);
    acc_cyc = cyc;
    @(negedge clk);
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
  endtask

  // Wait for a result, check it (latency from accept when lat >= 0), consume it.
  task automatic expectResult(input string tag, input logic [7:0] d, input bit ch,
                              input bit last, input bit err, input int lat);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_data"}, out_data, d);
    checkOutput({tag, "_ch_last_err"}, {out_ch, out_last, out_err}, {ch, last, err});
    checkOutput({tag, "_dec"}, core_dec, ch);
    if (lat >= 0) checkOutput({tag, "_latency"}, cyc - acc_cyc, lat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic raceTwo(input bit expFirst);
    int n = 0;
    bit first;
    ch0_valid = 1'b1; ch0_data = 8'h41; ch0_last = 1'b1;
    ch1_valid = 1'b1; ch1_data = 8'h43; ch1_last = 1'b1;
    while (!ch0_ready && !ch1_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    first = ch1_ready;
    checkOutput("race_first", first, expFirst);
    @(negedge clk);
    if (first) ch1_valid = 1'b0; else ch0_valid = 1'b0;
    expectResult("race_a", first ? 8'h44 : 8'h42, first, 1'b1, 1'b0, -1);
    n = 0;
    while (!(first ? ch0_ready : ch1_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("race_second_ready", first ? ch0_ready : ch1_ready, 1);
    @(negedge clk);
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
    expectResult("race_b", first ? 8'h42 : 8'h44, !first, 1'b1, 1'b0, -1);
  endtask

  initial begin
    int s, v, bad;

    // "AB" on ch0: one core_set first, then B->C results, latency 10.
    doReset();
    applyStimulus(1'b0, 8'h41, 1'b0);
    checkOutput("set_after_reset", set_cnt, 1);
    expectResult("ab_0", 8'h42, 1'b0, 1'b0, 1'b0, 10);
    applyStimulus(1'b0, 8'h42, 1'b1);
    expectResult("ab_1", 8'h43, 1'b0, 1'b1, 1'b0, 10);
    repeat (4) @(negedge clk);
    checkOutput("ab_set_once", set_cnt, 1);
    checkOutput("ab_core_valids", valid_cnt, 2);

    // Simultaneous requests: ch0 first, then ch1 first on the repeat.
    doReset();
    raceTwo(1'b0);
    raceTwo(1'b1);

    // Space bypasses the core; 'Z' decrypt path.
    v = valid_cnt;
    applyStimulus(1'b1, 8'h20, 1'b0);
    expectResult("space", 8'h20, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("space_no_core", valid_cnt, v);
    applyStimulus(1'b1, 8'h5A, 1'b1);
    expectResult("zed", 8'h5B, 1'b1, 1'b1, 1'b0, 10);

    // Output stall: result held, no byte accepted while full.
    applyStimulus(1'b0, 8'h4D, 1'b0);
    ch0_valid = 1'b1; ch0_data = 8'h4E; ch0_last = 1'b1;
    v = 0;
    while (!out_valid && v < 100) begin
      @(negedge clk);
      v++;
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((out_data !== 8'h4E) || !out_valid || ch0_ready || ch1_ready) bad++;
    end
    checkOutput("stall_hold", bad, 0);
    expectResult("stall_m", 8'h4E, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(1'b0, 8'h4E, 1'b1);
    expectResult("stall_n", 8'h4F, 1'b0, 1'b1, 1'b0, 10);

    // cfg_load mid-message: re-set deferred until message end, before ch1.
    applyStimulus(1'b0, 8'h41, 1'b0);
    expectResult("cfg_0", 8'h42, 1'b0, 1'b0, 1'b0, 10);
    s = set_cnt;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    applyStimulus(1'b0, 8'h42, 1'b0);
    expectResult("cfg_1", 8'h43, 1'b0, 1'b0, 1'b0, 10);
    applyStimulus(1'b0, 8'h43, 1'b1);
    expectResult("cfg_2", 8'h44, 1'b0, 1'b1, 1'b0, 10);
    checkOutput("cfg_no_set_mid_msg", set_cnt, s);
    applyStimulus(1'b1, 8'h51, 1'b1);
    checkOutput("cfg_set_before_ch1", set_cnt, s + 1);
    expectResult("cfg_ch1", 8'h52, 1'b1, 1'b1, 1'b0, 10);

    // Hung core: abort 16 cycles after ISSUE, then a re-set before next grant.
    stub_hang = 1'b1;
    applyStimulus(1'b0, 8'h54, 1'b1);
    expectResult("timeout", 8'h3F, 1'b0, 1'b1, 1'b1, 17);
    stub_hang = 1'b0;
    s = set_cnt;
    applyStimulus(1'b1, 8'h45, 1'b1);
    checkOutput("timeout_reset_core", set_cnt, s + 1);
    expectResult("after_timeout", 8'h46, 1'b1, 1'b1, 1'b0, 10);

    // Reset while waiting on the core: everything back to zero, no result.
    applyStimulus(1'b0, 8'h4B, 1'b1);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_wait", allOutputs(), 32'd0);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    checkOutput("no_partial_output", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
